// File: rtl/crypto_itf_ctrl_pkg.sv
// crypto_itf_pkg
// Shared definitions for the crypto core register interface:
//   - state_t       : controller FSM states
//   - CTRL_* / STAT_* : bit positions inside the CTRL and STATUS words
//   - *_addr()      : word addresses of the control registers, derived from
//                     the sizes of the input and output banks
package crypto_itf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int CTRL_START   = 0;
   localparam int CTRL_SOFT_RST = 1;
   localparam int CTRL_IRQ_EN  = 2;
   localparam int CTRL_CLR     = 3;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_ERR     = 2;
   localparam int STAT_TIMEOUT = 3;

   // The output bank sits directly after the input bank.
   function automatic int out_base_addr(input int in_reg);
      return in_reg;
   endfunction

   function automatic int ctrl_addr(input int in_reg, input int out_reg);
      return in_reg + out_reg;
   endfunction

   function automatic int status_addr(input int in_reg, input int out_reg);
      return in_reg + out_reg + 1;
   endfunction

   function automatic int cycles_addr(input int in_reg, input int out_reg);
      return in_reg + out_reg + 2;
   endfunction

endpackage

// File: rtl/crypto_itf_ctrl_if.sv
// crypto_itf_ctrl_if
// Host-side register bus: one word write or read per cycle.
//   we, re, addr, wdata : driven by the host (master)
//   rdata, rvalid       : driven by the register block (slave), one cycle
//                         after re
interface crypto_itf_ctrl_if #(
   parameter int WIDTH = 64,
   parameter int AW    = 8
) ();

   logic             we;
   logic             re;
   logic [AW-1:0]    addr;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] rdata;
   logic             rvalid;

   modport master (
      output we, re, addr, wdata,
      input  rdata, rvalid
   );

   modport slave (
      input  we, re, addr, wdata,
      output rdata, rvalid
   );

endinterface

// File: rtl/crypto_itf_ctrl_regbank.sv
// itf_regbank
// Bank of N_REG words of WIDTH bits.
//   clk, rst_n : clock, asynchronous active-low reset (bank cleared)
//   clr        : synchronous clear of the whole bank (highest priority)
//   load       : parallel load of the whole bank from load_data
//   we/widx/wdata : single-word write, word widx
//   q          : bank contents, word k at bits [k*WIDTH +: WIDTH]
module itf_regbank #(
   parameter int N_REG = 7,
   parameter int WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       we,
   input  logic [$clog2(N_REG+1)-1:0] widx,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       load,
   input  logic [N_REG*WIDTH-1:0]     load_data,
   output logic [N_REG*WIDTH-1:0]     q
);

   localparam int IW = $clog2(N_REG + 1);

   // Priority clear > load > word write; an index beyond N_REG-1 writes nothing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (load) begin
         q <= load_data;
      end else if (we) begin
         for (int k = 0; k < N_REG; k++) begin
            if (widx == IW'(k)) begin
               q[k*WIDTH +: WIDTH] <= wdata;
            end
         end
      end
   end

endmodule

// File: rtl/crypto_itf_ctrl.sv
// crypto_itf_ctrl
// Register interface between the host bus and a single-shot crypto core.
//   clk, i_rst : clock, asynchronous active-low reset
//   bus        : host register bus (we/re/addr/wdata in, rdata/rvalid out)
//   irq        : level interrupt, irq_en & (done | err | timeout)
//   core_rst   : active-high core reset, low only while a run is in progress
//   core_din   : input bank presented to the core
//   core_dout  : core result, captured when core_valid is seen in BUSY
//   core_valid : core result valid
module crypto_itf_ctrl
   import crypto_itf_pkg::*;
#(
   parameter int WIDTH   = 64,
   parameter int IN_REG  = 7,
   parameter int OUT_REG = 2,
   parameter int AW      = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic                      clk,
   input  logic                      i_rst,
   crypto_itf_ctrl_if.slave          bus,
   output logic                      irq,
   output logic                      core_rst,
   output logic [IN_REG*WIDTH-1:0]   core_din,
   input  logic [OUT_REG*WIDTH-1:0]  core_dout,
   input  logic                      core_valid
);

   localparam int IN_IW  = $clog2(IN_REG + 1);
   localparam int OUT_IW = $clog2(OUT_REG + 1);

   localparam logic [AW-1:0] OUT_BASE    = AW'(out_base_addr(IN_REG));
   localparam logic [AW-1:0] CTRL_ADDR   = AW'(ctrl_addr(IN_REG, OUT_REG));
   localparam logic [AW-1:0] STATUS_ADDR = AW'(status_addr(IN_REG, OUT_REG));
   localparam logic [AW-1:0] CYCLES_ADDR = AW'(cycles_addr(IN_REG, OUT_REG));
   localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);

   state_t                   state, state_next;
   logic                     done, done_next;
   logic                     err, err_next;
   logic                     tmo, tmo_next;
   logic                     irq_en, irq_en_next;
   logic [WIDTH-1:0]         cycles, cycles_next, cycles_inc;
   logic                     ctrl_wr, in_hit;
   logic                     in_we, in_clr, out_load;
   logic [IN_IW-1:0]         in_idx;
   logic [OUT_REG*WIDTH-1:0] out_q;
   logic [WIDTH-1:0]         rd_word, status_word;
   logic [WIDTH-1:0]         rdata_q;
   logic                     rvalid_q;

   assign ctrl_wr    = bus.we && (bus.addr == CTRL_ADDR);
   assign in_hit     = bus.addr < AW'(IN_REG);
   assign in_idx     = IN_IW'(bus.addr);
   assign cycles_inc = (&cycles) ? cycles : cycles + WIDTH'(1);

   // Next-state and flag logic. Events are layered so that later steps win:
   // clr first, then run progress and bus errors set flags, a start may
   // launch a new run, and soft_rst finally overrides everything.
   always_comb begin
      state_next  = state;
      done_next   = done;
      err_next    = err;
      tmo_next    = tmo;
      irq_en_next = irq_en;
      cycles_next = cycles;
      in_we       = 1'b0;
      in_clr      = 1'b0;
      out_load    = 1'b0;

      if (ctrl_wr) begin
         irq_en_next = bus.wdata[CTRL_IRQ_EN];
         if (bus.wdata[CTRL_CLR]) begin
            done_next = 1'b0;
            err_next  = 1'b0;
            tmo_next  = 1'b0;
         end
      end

      if (state == ST_BUSY) begin
         cycles_next = cycles_inc;
         if (core_valid) begin
            out_load   = 1'b1;
            done_next  = 1'b1;
            state_next = ST_DONE;
         end else if (cycles_inc == TIMEOUT_W) begin
            tmo_next   = 1'b1;
            state_next = ST_DONE;
         end
      end

      // The input bank stays frozen while the core is consuming it.
      if (bus.we && in_hit) begin
         if (state == ST_BUSY) begin
            err_next = 1'b1;
         end else begin
            in_we = 1'b1;
         end
      end

      if (ctrl_wr && bus.wdata[CTRL_START]) begin
         if (state == ST_BUSY) begin
            err_next = 1'b1;
         end else begin
            state_next  = ST_BUSY;
            cycles_next = '0;
            done_next   = 1'b0;
            tmo_next    = 1'b0;
         end
      end

      // irq_en and the output bank deliberately survive a soft reset.
      if (ctrl_wr && bus.wdata[CTRL_SOFT_RST]) begin
         state_next  = ST_IDLE;
         irq_en_next = irq_en;
         cycles_next = cycles;
         done_next   = 1'b0;
         err_next    = 1'b0;
         tmo_next    = 1'b0;
         in_clr      = 1'b1;
         out_load    = 1'b0;
      end
   end

   // Controller state, flags and the busy-cycle counter.
   always_ff @(posedge clk or negedge i_rst) begin
      if (!i_rst) begin
         state  <= ST_IDLE;
         done   <= 1'b0;
         err    <= 1'b0;
         tmo    <= 1'b0;
         irq_en <= 1'b0;
         cycles <= '0;
      end else begin
         state  <= state_next;
         done   <= done_next;
         err    <= err_next;
         tmo    <= tmo_next;
         irq_en <= irq_en_next;
         cycles <= cycles_next;
      end
   end

   itf_regbank #(
      .N_REG (IN_REG),
      .WIDTH (WIDTH)
   ) u_in_bank (
      .clk       (clk),
      .rst_n     (i_rst),
      .clr       (in_clr),
      .we        (in_we),
      .widx      (in_idx),
      .wdata     (bus.wdata),
      .load      (1'b0),
      .load_data ('0),
      .q         (core_din)
   );

   itf_regbank #(
      .N_REG (OUT_REG),
      .WIDTH (WIDTH)
   ) u_out_bank (
      .clk       (clk),
      .rst_n     (i_rst),
      .clr       (1'b0),
      .we        (1'b0),
      .widx      ({OUT_IW{1'b0}}),
      .wdata     ('0),
      .load      (out_load),
      .load_data (core_dout),
      .q         (out_q)
   );

   // Read decode; CTRL and unmapped addresses fall through to zero.
   always_comb begin
      status_word               = '0;
      status_word[STAT_BUSY]    = (state == ST_BUSY);
      status_word[STAT_DONE]    = done;
      status_word[STAT_ERR]     = err;
      status_word[STAT_TIMEOUT] = tmo;

      rd_word = '0;
      for (int k = 0; k < IN_REG; k++) begin
         if (bus.addr == AW'(k)) begin
            rd_word = core_din[k*WIDTH +: WIDTH];
         end
      end
      for (int k = 0; k < OUT_REG; k++) begin
         if (bus.addr == OUT_BASE + AW'(k)) begin
            rd_word = out_q[k*WIDTH +: WIDTH];
         end
      end
      if (bus.addr == STATUS_ADDR) begin
         rd_word = status_word;
      end
      if (bus.addr == CYCLES_ADDR) begin
         rd_word = cycles;
      end
   end

   // Registered read port; rdata holds until the next read.
   always_ff @(posedge clk or negedge i_rst) begin
      if (!i_rst) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= bus.re;
         if (bus.re) begin
            rdata_q <= rd_word;
         end
      end
   end

   assign bus.rdata  = rdata_q;
   assign bus.rvalid = rvalid_q;
   assign core_rst   = (state != ST_BUSY);
   assign irq        = irq_en & (done | err | tmo);

endmodule
